// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS-I subset core: one shared ALU and register file, stepped by an FSM,
// with a unified instruction/data memory behind a req/ready handshake.
module mips_multi_cycle #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_W     = 32,
  parameter bit          CLEAR_REGS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       pc_o
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] target_q, target_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic        halted_q, halted_d;

  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic [31:0] rs_val, rt_val;
  logic        funct_ok;
  logic [31:0] alu_b, alu_res;
  logic [31:0] mem_addr_full;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  // $0 reads as zero whatever the array holds, so CLEAR_REGS=0 stays correct.
  assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

  assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);

  always_comb begin
    alu_b   = (opcode == OP_RTYPE) ? b_q : imm_sext;
    alu_res = a_q + alu_b;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SUB:  alu_res = a_q - b_q;
        FN_AND:  alu_res = a_q & b_q;
        FN_OR:   alu_res = a_q | b_q;
        FN_SLT:  alu_res = {31'd0, ($signed(a_q) < $signed(b_q))};
        default: alu_res = a_q + b_q;
      endcase
    end
  end

  // Request is purely a function of state and is dropped the moment reset rises.
  assign mem_req       = !reset && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign mem_we        = mem_req && (state_q == S_MEM) && (opcode == OP_SW);
  assign mem_addr_full = (state_q == S_MEM) ? alu_q : pc_q;
  assign mem_addr      = mem_addr_full[ADDR_W-1:0];
  assign mem_wdata     = b_q;
  assign halted        = halted_q;
  assign pc_o          = pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    target_d = target_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    halted_d = halted_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_q;

    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d      = rs_val;
        b_d      = rt_val;
        target_d = pc_q + (imm_sext << 2);
        case (opcode)
          OP_J: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            state_d = S_FETCH;
          end
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          OP_RTYPE: state_d = funct_ok ? S_EXEC : S_FETCH;
          OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: state_d = S_EXEC;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXEC: begin
        alu_d = alu_res;
        case (opcode)
          OP_BEQ: begin
            if (a_q == b_q) pc_d = target_q;
            state_d = S_FETCH;
          end
          OP_BNE: begin
            if (a_q != b_q) pc_d = target_q;
            state_d = S_FETCH;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        if (opcode == OP_RTYPE) begin
          rf_waddr = rd;
        end else if (opcode == OP_LW) begin
          rf_wdata = mdr_q;
        end
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      target_q <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      target_q <= target_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      halted_q <= halted_d;
    end
  end

  generate
    if (CLEAR_REGS) begin : g_rf_clear
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
          rf_q[rf_waddr] <= rf_wdata;
        end
      end
    end else begin : g_rf_keep
      always_ff @(posedge clk) begin
        if (rf_we && (rf_waddr != 5'd0)) begin
          rf_q[rf_waddr] <= rf_wdata;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mips_multi_cycle.sv
// Self-checking bench for mips_multi_cycle: a memory model with random wait states and an
// instruction-level reference interpreter that predicts the access trace and cycle count.
module tb_mips_multi_cycle;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready = 1'b0;
  logic        halted;
  logic [31:0] pc_o;

  mips_multi_cycle #(.RESET_PC(RESET_PC), .ADDR_W(32), .CLEAR_REGS(1'b1)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  logic [31:0] tmem [1024];
  logic [31:0] mm   [1024];
  logic [31:0] prog [$];
  acc_t        acc_log [$];
  acc_t        exp_acc [$];
  int          exp_cycles;
  logic [31:0] exp_pc;

  int   n_checks = 0;
  int   n_pass   = 0;

  int   fixed_wait = 0;
  int   rand_max   = 0;
  bit   stall_stores = 1'b0;
  bit   new_acc = 1'b1;
  bit   fire_pending = 1'b0;
  acc_t fire_acc;
  acc_t hold_acc;
  int   cur_wait = 0;
  int   wcnt = 0;
  int   total_waits = 0;

  assign mem_rdata = tmem[mem_addr[11:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Memory side: decide ready at each falling edge, log completed handshakes one edge later.
  always @(negedge clk) begin
    if (fire_pending) begin
      acc_log.push_back(fire_acc);
      if (fire_acc.we) tmem[fire_acc.addr[11:2]] = fire_acc.data;
      new_acc      = 1'b1;
      fire_pending = 1'b0;
    end
    if (mem_req) begin
      if (new_acc) begin
        cur_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(rand_max, 0));
        wcnt     = 0;
        new_acc  = 1'b0;
        hold_acc = '{mem_we, mem_addr, mem_wdata};
      end else begin
        chk("hold_addr", mem_addr, hold_acc.addr);
        chk("hold_we", {31'd0, mem_we}, {31'd0, hold_acc.we});
        if (hold_acc.we) chk("hold_wdata", mem_wdata, hold_acc.data);
      end
      mem_ready = (wcnt >= cur_wait) && !(stall_stores && mem_we);
      wcnt++;
      if (mem_ready) begin
        fire_pending = 1'b1;
        fire_acc     = '{mem_we, mem_addr, mem_wdata};
      end else begin
        total_waits++;
      end
    end else begin
      mem_ready = 1'($urandom_range(1, 0));
    end
  end

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(logic [31:0] target);
    return {6'h02, target[27:2]};
  endfunction

  localparam logic [31:0] HALT_W = {6'h3F, 26'd0};

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) tmem[i] = 32'd0;
    for (int i = 0; i < prog.size(); i++) tmem[i] = prog[i];
    mm = tmem;
  endtask

  // Instruction-level interpreter: architectural effect plus per-step cycle cost
  // (fetch+decode 2, exec 1, mem 1, writeback 1; wait states added from the memory side).
  task automatic run_model();
    logic [31:0] r [32];
    logic [31:0] pc, ir, a, b, imm, res, ea;
    bit done, known;
    int steps;
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    pc = RESET_PC; exp_acc.delete(); exp_cycles = 0; done = 1'b0; steps = 0;
    while (!done && steps < 2000) begin
      steps++;
      ir = mm[pc[11:2]];
      exp_acc.push_back('{1'b0, pc, 32'd0});
      pc = pc + 4;
      exp_cycles += 2;
      a = r[ir[25:21]]; b = r[ir[20:16]]; imm = {{16{ir[15]}}, ir[15:0]};
      ea = a + imm;
      case (ir[31:26])
        6'h00: begin
          known = 1'b1; res = 32'd0;
          case (ir[5:0])
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: known = 1'b0;
          endcase
          if (known) begin
            exp_cycles += 2;
            if (ir[15:11] != 5'd0) r[ir[15:11]] = res;
          end
        end
        6'h08: begin exp_cycles += 2; if (ir[20:16] != 5'd0) r[ir[20:16]] = ea; end
        6'h23: begin
          exp_cycles += 3;
          exp_acc.push_back('{1'b0, ea, 32'd0});
          if (ir[20:16] != 5'd0) r[ir[20:16]] = mm[ea[11:2]];
        end
        6'h2B: begin
          exp_cycles += 2;
          exp_acc.push_back('{1'b1, ea, b});
          mm[ea[11:2]] = b;
        end
        6'h04: begin exp_cycles += 1; if (a == b) pc = pc + (imm << 2); end
        6'h05: begin exp_cycles += 1; if (a != b) pc = pc + (imm << 2); end
        6'h02: pc = {pc[31:28], ir[25:0], 2'b00};
        6'h3F: done = 1'b1;
        default: ;
      endcase
    end
    exp_pc = pc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    acc_log.delete();
    new_acc = 1'b1; fire_pending = 1'b0; total_waits = 0;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", pc_o, RESET_PC);
    #1 reset = 1'b0;
  endtask

  task automatic run_and_compare(input string tname);
    int cycles, n, sz;
    cycles = 0;
    while (!halted && cycles < 5000) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk({tname, "/halted"}, {31'd0, halted}, 32'd1);
    @(negedge clk);
    chk({tname, "/n_acc"}, acc_log.size(), exp_acc.size());
    n = (acc_log.size() < exp_acc.size()) ? acc_log.size() : exp_acc.size();
    for (int i = 0; i < n; i++) begin
      chk({tname, "/acc_addr"}, acc_log[i].addr, exp_acc[i].addr);
      chk({tname, "/acc_we"}, {31'd0, acc_log[i].we}, {31'd0, exp_acc[i].we});
      if (exp_acc[i].we) chk({tname, "/acc_wdata"}, acc_log[i].data, exp_acc[i].data);
    end
    chk({tname, "/cycles"}, cycles, exp_cycles + total_waits);
    chk({tname, "/pc_at_halt"}, pc_o, exp_pc);
    sz = acc_log.size();
    repeat (6) @(negedge clk);
    chk({tname, "/halt_quiet"}, acc_log.size(), sz);
    chk({tname, "/halt_sticky"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic prog1();
    prog.delete();
    prog.push_back(enc_i(6'h08, 0, 1, 5));
    prog.push_back(enc_i(6'h08, 0, 2, 7));
    prog.push_back(enc_r(1, 2, 3, 6'h20));
    prog.push_back(enc_i(6'h2B, 0, 3, 'h40));
    prog.push_back(HALT_W);
  endtask

  initial begin
    int idx, cnt, nst;
    logic [31:0] w;

    // 1: straight-line program, zero wait
    prog1(); load_prog(); run_model();
    fixed_wait = 0; do_reset(); run_and_compare("t1");
    chk("t1/store_data", tmem['h40 >> 2], 32'd12);

    // 2: same program, three wait cycles on every access
    prog1(); load_prog(); run_model();
    fixed_wait = 3; do_reset(); run_and_compare("t2");
    chk("t2/store_data", tmem['h40 >> 2], 32'd12);
    chk("t2/waits", total_waits, 3 * exp_acc.size());

    // 3: countdown loop plus one taken and one untaken beq
    prog.delete();
    prog.push_back(enc_i(6'h08, 0, 1, 3));
    prog.push_back(enc_i(6'h08, 1, 1, -1));
    prog.push_back(enc_i(6'h05, 1, 0, -2));
    prog.push_back(enc_i(6'h2B, 0, 1, 0));
    prog.push_back(enc_i(6'h04, 1, 0, 1));
    prog.push_back(enc_i(6'h08, 0, 6, 1));
    prog.push_back(enc_i(6'h08, 0, 7, 1));
    prog.push_back(enc_i(6'h04, 7, 0, 1));
    prog.push_back(enc_i(6'h2B, 0, 7, 4));
    prog.push_back(enc_i(6'h2B, 0, 6, 8));
    prog.push_back(HALT_W);
    load_prog(); run_model();
    fixed_wait = -1; rand_max = 2; do_reset(); run_and_compare("t3");
    cnt = 0;
    foreach (acc_log[i]) if (!acc_log[i].we && acc_log[i].addr == 32'h4) cnt++;
    chk("t3/loop_iters", cnt, 3);
    chk("t3/store0", tmem[0], 32'd0);
    chk("t3/beq_taken_skip", tmem[2], 32'd0);
    chk("t3/beq_untaken", tmem[1], 32'd1);

    // 4: store/load round trip, $0 immutability, sub wrap, signed slt, and/or
    prog.delete();
    prog.push_back(enc_i(6'h08, 0, 3, 'h1234));
    prog.push_back(enc_i(6'h2B, 0, 3, 'h80));
    prog.push_back(enc_i(6'h23, 0, 4, 'h80));
    prog.push_back(enc_i(6'h08, 0, 0, 9));
    prog.push_back(enc_i(6'h2B, 0, 4, 'h84));
    prog.push_back(enc_i(6'h2B, 0, 0, 'h88));
    prog.push_back(enc_i(6'h08, 0, 5, 3));
    prog.push_back(enc_i(6'h08, 0, 6, 5));
    prog.push_back(enc_r(5, 6, 7, 6'h22));
    prog.push_back(enc_i(6'h2B, 0, 7, 'h8C));
    prog.push_back(enc_i(6'h08, 0, 8, -1));
    prog.push_back(enc_i(6'h08, 0, 9, 1));
    prog.push_back(enc_r(8, 9, 10, 6'h2A));
    prog.push_back(enc_i(6'h2B, 0, 10, 'h90));
    prog.push_back(enc_r(3, 8, 11, 6'h24));
    prog.push_back(enc_r(5, 6, 12, 6'h25));
    prog.push_back(enc_i(6'h2B, 0, 11, 'h94));
    prog.push_back(enc_i(6'h2B, 0, 12, 'h98));
    prog.push_back(HALT_W);
    load_prog(); run_model();
    fixed_wait = -1; rand_max = 3; do_reset(); run_and_compare("t4");
    chk("t4/lw_eq_sw", tmem['h84 >> 2], 32'h1234);
    chk("t4/r0_zero", tmem['h88 >> 2], 32'd0);
    chk("t4/sub_wrap", tmem['h8C >> 2], 32'hFFFF_FFFE);
    chk("t4/slt_signed", tmem['h90 >> 2], 32'd1);
    chk("t4/and", tmem['h94 >> 2], 32'h1234);
    chk("t4/or", tmem['h98 >> 2], 32'd7);

    // 5: jump, then an unknown opcode and an unknown funct behave as NOPs
    prog.delete();
    prog.push_back(enc_j(32'h100));
    for (int i = 1; i < 64; i++) prog.push_back(HALT_W);
    prog.push_back({6'h3E, 26'h155_5555});
    prog.push_back(enc_r(0, 0, 1, 6'h3B));
    prog.push_back(enc_i(6'h08, 0, 1, 1));
    prog.push_back(enc_i(6'h2B, 0, 1, 'h300));
    prog.push_back(HALT_W);
    load_prog(); run_model();
    fixed_wait = 0; do_reset(); run_and_compare("t5");
    if (acc_log.size() >= 3) begin
      chk("t5/jump_fetch", acc_log[1].addr, 32'h100);
      chk("t5/nop_next", acc_log[2].addr, 32'h104);
    end else begin
      chk("t5/trace_len", acc_log.size(), 3);
    end
    chk("t5/store", tmem['h300 >> 2], 32'd1);

    // 6: reset raised while the store is stalled in its memory access
    prog1(); load_prog(); run_model();
    fixed_wait = 0; stall_stores = 1'b1; do_reset();
    cnt = 0;
    while (!(mem_req && mem_we) && cnt < 200) begin @(negedge clk); cnt++; end
    chk("t6/sw_reached", {31'd0, mem_req && mem_we}, 32'd1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("t6/req_drop", {31'd0, mem_req}, 32'd0);
    nst = 0;
    foreach (acc_log[i]) if (acc_log[i].we) nst++;
    chk("t6/no_store", nst, 0);
    chk("t6/mem_untouched", tmem['h40 >> 2], 32'd0);
    stall_stores = 1'b0;
    do_reset(); run_and_compare("t6");
    chk("t6/first_fetch", (acc_log.size() > 0) ? acc_log[0].addr : 32'hDEAD_BEEF, RESET_PC);

    // 7: random ALU programs, results dumped via stores, random wait states
    for (int t = 0; t < 3; t++) begin
      prog.delete();
      for (int i = 0; i < 20; i++) begin
        idx = $urandom_range(5, 0);
        if (idx == 0) begin
          prog.push_back(enc_i(6'h08, $urandom_range(7, 0), $urandom_range(7, 1), $urandom_range(16'hFFFF, 0)));
        end else begin
          case (idx)
            1: w = 32'h20; 2: w = 32'h22; 3: w = 32'h24; 4: w = 32'h25; default: w = 32'h2A;
          endcase
          prog.push_back(enc_r($urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0), w[5:0]));
        end
      end
      for (int r = 0; r < 8; r++) prog.push_back(enc_i(6'h2B, 0, r, 'h200 + 4 * r));
      prog.push_back(enc_i(6'h23, 0, 1, 'h21C));
      prog.push_back(enc_i(6'h2B, 0, 1, 'h240));
      prog.push_back(HALT_W);
      load_prog(); run_model();
      fixed_wait = -1; rand_max = 3; do_reset(); run_and_compare("t7");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
